fft_frame_driver: RTL
=====================

# fft_frame_driver

Host-side driver for the 64-point FFT core: it accepts a stream of complex time-domain samples, pushes one frame into the FFT core's load port, starts the transform and waits for `done`. It then reads all 64 frequency bins back through the core's read-address port and emits them as a valid/ready stream. It sits between the sample front end and the pitch-analysis logic. It is the only block that drives the FFT core's `load`, `data_in`, `start` and `read_address`.

## Interface
- `N_POINTS`, 64: frame length; must equal the FFT core size.
- `ADDR_W`, 6: bin index width, log2(N_POINTS).
- `DATA_W`, 32: sample/bin width; real in [31:16], imag in [15:0], both two's complement.
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: synchronous, active-low.
- `s_valid` in 1, `s_ready` out 1, `s_data` in DATA_W: input sample stream.
- `fft_load` out 1: high on each cycle a sample is written into the core.
- `fft_data_in` out DATA_W: sample to the core; equals `s_data`.
- `fft_start` out 1: one-cycle start pulse.
- `fft_done` in 1: core transform complete (level).
- `fft_read_address` out ADDR_W: bin read address.
- `fft_data_out` in DATA_W: bin data, valid exactly 1 cycle after address.
- `m_valid` out 1, `m_ready` in 1, `m_data` out DATA_W: output bin stream.
- `m_index` out ADDR_W: bin number of `m_data`.
- `m_last` out 1: high with bin N_POINTS-1.
- `busy` out 1: high in any state other than LOAD.

## Operation
- States: LOAD -> START -> WAIT -> READ -> LOAD.
- LOAD: `s_ready`=1. Accept = `s_valid`&`s_ready`. `fft_load`=accept and `fft_data_in`=`s_data`, both combinational. Load counter increments per accept. The 64th accept moves to START; the counter returns to 0.
- START: `fft_start`=1 for exactly this one cycle, then WAIT.
- WAIT: when `fft_done`=1, go to READ. `fft_done` is ignored in all other states.
- READ: the read counter drives `fft_read_address` from a register, starting at 0.
  - A read is issued when output FIFO occupancy plus in-flight reads is less than 2, and the counter is below N_POINTS.
  - Returned data is captured 1 cycle later into a 2-entry output FIFO, tagged with its index.
  - `m_valid` = FIFO non-empty. Pop on `m_valid`&`m_ready`.
  - When the beat with `m_last`=1 is popped, go to LOAD.
- Every bin is emitted exactly once, in order 0..63. There are no drops or duplicates under any `m_ready` pattern.
- `m_data`, `m_index` and `m_last` hold stable while `m_valid`=1 and `m_ready`=0.

## Timing
- Reset (`reset`=0 at a clock edge): state=LOAD and all counters 0; FIFO and in-flight reads are discarded.
  - During reset: `s_ready`, `fft_load`, `fft_start`, `m_valid`, `m_last` and `busy` are 0; `fft_read_address`, `m_index` and `m_data` are 0.
  - `s_ready`=1 from the first cycle with `reset`=1.
- Reset mid-frame in any state aborts the frame. No `fft_start` or `m_valid` is produced for the aborted frame.
- Last sample accepted at cycle T: `fft_start`=1 at T+1, WAIT from T+2. `s_ready`=0 from T+1.
- `fft_done` high at cycle D: READ at D+1, first address 0 at D+1, first `m_valid` at D+3.
- With `m_ready` held at 1, one bin is emitted per cycle: 64 beats in 64 consecutive cycles.
- After the `m_last` pop at cycle L: `s_ready`=1 at L+1.
- Sample and bin phases never overlap; inputs are back-pressured during START/WAIT/READ.

## Configuration
- `FFT_FRAME_DRIVER_MAG_EN` defined: `m_data` carries an approximate magnitude instead of complex data.
  - Formula: `max(|re|,|im|) + (min(|re|,|im|)>>1)`, a 17-bit unsigned value zero-extended to DATA_W.
  - Computed combinationally on `fft_data_out` before FIFO capture, so latency is unchanged.
  - |−32768| = 32768.
- Undefined: `m_data` equals `fft_data_out` unmodified.

## Test plan
- Reset: hold `reset`=0 for 3 cycles mid-READ at bin 20 -> all outputs 0 during reset; `m_valid`=0 afterwards until a new frame; `s_ready`=1 on the first cycle after release.
- Load: 64 back-to-back samples with `s_data`=i -> `fft_load` high for 64 cycles with `fft_data_in`=0..63; `fft_start` high for exactly 1 cycle, the cycle after the 64th sample; `s_ready`=0 from that same cycle; a 65th `s_valid` is not accepted.
- Readout: core model asserts `fft_done` 10 cycles after start and returns `fft_data_out`=addr*0x00010001 one cycle after address; `m_ready`=1 -> 64 beats on consecutive cycles with `m_data`=0x00000000..0x003F003F, `m_index`=0..63, `m_last` only on 63.
- Backpressure: random `m_ready` at 30% duty -> identical 64-beat sequence; beats stable while stalled; `s_ready`=1 the cycle after the last pop.
- Spurious done: `fft_done`=1 during LOAD -> no state change; frame still requires 64 samples.
- `FFT_FRAME_DRIVER_MAG_EN`: re=−3, im=8 -> `m_data`=9; re=0x8000, im=0x8000 -> `m_data`=49152; re=0, im=0 -> 0.

Source files
------------

// File: rtl/fft_frame_driver.sv
// Frame driver for the 64-point FFT core: loads one frame, starts it, then streams the bins out.
// Optional FFT_FRAME_DRIVER_MAG_EN replaces complex bin data with an approximate magnitude.
module fft_frame_driver #(
   parameter int N_POINTS = 64,
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              fft_load,
   output logic [DATA_W-1:0] fft_data_in,
   output logic              fft_start,
   input  logic              fft_done,
   output logic [ADDR_W-1:0] fft_read_address,
   input  logic [DATA_W-1:0] fft_data_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [ADDR_W-1:0] m_index,
   output logic              m_last,
   output logic              busy
);

   // state   | meaning
   // S_LOAD  | accepting samples into the core
   // S_START | one-cycle start pulse to the core
   // S_WAIT  | waiting for the core's done level
   // S_READ  | reading bins into the output FIFO and streaming them
   typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_READ} state_t;

   state_t            state;
   logic [ADDR_W-1:0] load_cnt;
   logic [ADDR_W:0]   rd_cnt;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_idx;
   logic [DATA_W-1:0] fifo_data [2];
   logic [ADDR_W-1:0] fifo_idx [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic [1:0]        fifo_cnt;

   logic              accept;
   logic              pop;
   logic              issue;
   logic [1:0]        occ;
   logic [DATA_W-1:0] cap_data;

`ifdef FFT_FRAME_DRIVER_MAG_EN
   logic [16:0] re_abs;
   logic [16:0] im_abs;
   logic [16:0] mag_max;
   logic [16:0] mag_min;
   logic [16:0] mag;

   // 17-bit absolute values so that |-32768| is representable
   always_comb begin
      re_abs  = fft_data_out[31] ? (17'd0 - {1'b1, fft_data_out[31:16]})
                                 : {1'b0, fft_data_out[31:16]};
      im_abs  = fft_data_out[15] ? (17'd0 - {1'b1, fft_data_out[15:0]})
                                 : {1'b0, fft_data_out[15:0]};
      mag_max = (re_abs > im_abs) ? re_abs : im_abs;
      mag_min = (re_abs > im_abs) ? im_abs : re_abs;
      mag     = mag_max + (mag_min >> 1);
      cap_data = {{(DATA_W-17){1'b0}}, mag};
   end
`else
   assign cap_data = fft_data_out;
`endif

   assign s_ready          = reset & (state == S_LOAD);
   assign accept           = s_valid & s_ready;
   assign fft_load         = accept;
   assign fft_data_in      = s_data;
   assign fft_start        = reset & (state == S_START);
   assign busy             = reset & (state != S_LOAD);
   assign fft_read_address = reset ? rd_cnt[ADDR_W-1:0] : '0;

   assign m_valid = reset & (fifo_cnt != 2'd0);
   assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
   assign m_index = m_valid ? fifo_idx[rd_ptr] : '0;
   assign m_last  = m_valid & (fifo_idx[rd_ptr] == ADDR_W'(N_POINTS - 1));
   assign pop     = m_valid & m_ready;

   // Occupancy after this cycle's pop lets a full-rate stream issue one read per cycle
   assign occ   = fifo_cnt - 2'(pop) + 2'(inflight);
   assign issue = (state == S_READ) && (rd_cnt < (ADDR_W+1)'(N_POINTS)) && (occ < 2'd2);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_LOAD;
         load_cnt     <= '0;
         rd_cnt       <= '0;
         inflight     <= 1'b0;
         inflight_idx <= '0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         fifo_cnt     <= 2'd0;
         for (int k = 0; k < 2; k++) begin
            fifo_data[k] <= '0;
            fifo_idx[k]  <= '0;
         end
      end else begin
         case (state)
            S_LOAD: begin
               if (accept) begin
                  if (load_cnt == ADDR_W'(N_POINTS - 1)) begin
                     load_cnt <= '0;
                     state    <= S_START;
                  end else begin
                     load_cnt <= load_cnt + 1'b1;
                  end
               end
            end
            S_START: state <= S_WAIT;
            S_WAIT: begin
               if (fft_done) state <= S_READ;
            end
            S_READ: begin
               if (pop && m_last) begin
                  state  <= S_LOAD;
                  rd_cnt <= '0;
               end else if (issue) begin
                  rd_cnt <= rd_cnt + 1'b1;
               end
            end
            default: state <= S_LOAD;
         endcase

         inflight <= issue;
         if (issue) inflight_idx <= rd_cnt[ADDR_W-1:0];

         if (inflight) begin
            fifo_data[wr_ptr] <= cap_data;
            fifo_idx[wr_ptr]  <= inflight_idx;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
      end
   end

endmodule
